// File: rtl/store_write_buffer_if.sv
// Store-side and memory-side handshake bundle for the store write buffer.
// master = core/memory environment side, slave = the buffer itself.
interface store_write_buffer_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  st_valid;
   logic                  st_ready;
   logic [ADDR_WIDTH-1:0] st_addr;
   logic [31:0]           st_wdata;
   logic [3:0]            st_wmask;

   logic                  mem_valid;
   logic                  mem_ready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [3:0]            mem_wstrb;

   modport master (
      output st_valid, st_addr, st_wdata, st_wmask, mem_ready,
      input  st_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      input  st_valid, st_addr, st_wdata, st_wmask, mem_ready,
      output st_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/store_write_buffer.sv
// In-order FIFO of aligned stores drained onto a valid/ready memory bus,
// with a load/store word-address hazard flag over all pending entries.
module store_write_buffer #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         resetn,
   store_write_buffer_if.slave          bus,
   input  logic [ADDR_WIDTH-1:0]        ld_addr,
   output logic                         ld_hazard,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int WW = ADDR_WIDTH - 2;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [WW-1:0]   r_ent_addr [DEPTH];
   logic [31:0]     r_ent_data [DEPTH];
   logic [3:0]      r_ent_mask [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   w_rd_ptr_nxt;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_nxt;
   logic [WW-1:0]   r_out_addr;
   logic [31:0]     r_out_data;
   logic [3:0]      r_out_strb;
   logic            w_push;
   logic            w_pop;
   logic            w_load;
   logic            w_load_bypass;
   logic [PW-1:0]   w_load_ptr;
   logic            w_unused;

   assign bus.st_ready = (r_count != CW'(DEPTH));
   assign w_push       = bus.st_valid && bus.st_ready && (bus.st_wmask != 4'b0000);
   assign w_pop        = (r_state == BUSY) && bus.mem_ready;
   assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
   assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PW'(1'b1)) : r_rd_ptr;
   assign w_unused     = ^{bus.st_addr[1:0], ld_addr[1:0]};

   assign bus.mem_valid = (r_state == BUSY);
   assign bus.mem_addr  = {r_out_addr, 2'b00};
   assign bus.mem_wdata = r_out_data;
   assign bus.mem_wstrb = r_out_strb;
   assign empty         = (r_count == {CW{1'b0}}) && !bus.mem_valid;
   assign count         = r_count;

   // Bus-side next state and head-load selection
   always_comb begin
      w_state_nxt   = r_state;
      w_load        = 1'b0;
      w_load_bypass = 1'b0;
      w_load_ptr    = r_rd_ptr;
      case (r_state)
         IDLE: begin
            if (r_count != {CW{1'b0}}) begin
               w_state_nxt = BUSY;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         BUSY: begin
            if (w_pop) begin
               if (w_count_nxt != {CW{1'b0}}) begin
                  w_state_nxt   = BUSY;
                  w_load        = 1'b1;
                  w_load_ptr    = w_rd_ptr_nxt;
                  // Last entry retiring while a new store lands: that store is the next head
                  w_load_bypass = (r_count == CW'(1'b1));
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_state_nxt = BUSY;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Bus FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // Pointers and occupancy
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         r_wr_ptr <= w_push ? (r_wr_ptr + PW'(1'b1)) : r_wr_ptr;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
      end
   end

   // Entry storage, deliberately not reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_ent_addr[r_wr_ptr] <= bus.st_addr[ADDR_WIDTH-1:2];
         r_ent_data[r_wr_ptr] <= bus.st_wdata;
         r_ent_mask[r_wr_ptr] <= bus.st_wmask;
      end
   end

   // Registered head presented on the memory bus
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_out_addr <= {WW{1'b0}};
         r_out_data <= 32'h0000_0000;
         r_out_strb <= 4'b0000;
      end else if (w_load) begin
         r_out_addr <= w_load_bypass ? bus.st_addr[ADDR_WIDTH-1:2] : r_ent_addr[w_load_ptr];
         r_out_data <= w_load_bypass ? bus.st_wdata : r_ent_data[w_load_ptr];
         r_out_strb <= w_load_bypass ? bus.st_wmask : r_ent_mask[w_load_ptr];
      end
   end

   // Word-address match against every pending entry, including the one on the bus
   always_comb begin
      ld_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < r_count) &&
             (r_ent_addr[r_rd_ptr + PW'(i)] == ld_addr[ADDR_WIDTH-1:2])) begin
            ld_hazard = 1'b1;
         end else begin
            ld_hazard = ld_hazard;
         end
      end
   end
endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: scoreboard of accepted stores
// compared against memory-side writes, plus per-scenario directed checks.
module tb_store_write_buffer;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } txn_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] ld_addr;
   logic        ld_hazard;
   logic        empty;
   logic [2:0]  count;

   int   n_vec = 0;
   int   n_err = 0;
   int   m_count = 0;
   txn_t sb[$];

   store_write_buffer_if #(.ADDR_WIDTH(32)) bus ();

   store_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .ld_addr   (ld_addr),
      .ld_hazard (ld_hazard),
      .empty     (empty),
      .count     (count)
   );

   always #5 clk = ~clk;

   // Scoreboard: push accepted stores, pop and compare on each memory write
   always @(negedge clk) begin
      logic ready_m;
      txn_t got;
      txn_t exp_t;
      if (!resetn) begin
         m_count = 0;
         sb.delete();
      end else begin
         ready_m = (m_count != DEPTH);
         n_vec++;
         if (count !== 3'(m_count)) begin
            n_err++;
            $display("FAIL count_track: got %0d want %0d", count, m_count);
         end
         n_vec++;
         if (bus.st_ready !== ready_m) begin
            n_err++;
            $display("FAIL st_ready_track: got %b want %b", bus.st_ready, ready_m);
         end
         if (bus.mem_valid === 1'b1 && bus.mem_ready === 1'b1) begin
            got = {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb};
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL spurious_write: got addr %h data %h strb %b, want no write",
                        bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
            end else begin
               exp_t = sb.pop_front();
               m_count--;
               if (got !== exp_t) begin
                  n_err++;
                  $display("FAIL mem_write: got %h/%h/%b want %h/%h/%b",
                           got.addr, got.data, got.strb, exp_t.addr, exp_t.data, exp_t.strb);
               end
            end
         end
         if (bus.st_valid === 1'b1 && ready_m && bus.st_wmask != 4'b0000) begin
            sb.push_back({bus.st_addr & 32'hFFFF_FFFC, bus.st_wdata, bus.st_wmask});
            m_count++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic offer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      bus.st_valid = 1'b1;
      bus.st_addr  = a;
      bus.st_wdata = d;
      bus.st_wmask = m;
   endtask

   task automatic test_reset();
      bus.st_valid = 1'b0; bus.st_addr = 32'h0; bus.st_wdata = 32'h0;
      bus.st_wmask = 4'b0000; bus.mem_ready = 1'b0; ld_addr = 32'h0;
      resetn = 1'b0;
      #12;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
      chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
      step();
      resetn = 1'b1;
      step();
   endtask

   task automatic test_single();
      offer(32'h0000_1006, 32'hAB00_0000, 4'b1000);
      step();
      bus.st_valid = 1'b0;
      chk("single_not_yet_valid", 32'(bus.mem_valid), 32'd0);
      step();
      chk("single_valid", 32'(bus.mem_valid), 32'd1);
      chk("single_addr", bus.mem_addr, 32'h0000_1004);
      chk("single_wdata", bus.mem_wdata, 32'hAB00_0000);
      chk("single_wstrb", 32'(bus.mem_wstrb), 32'h8);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("single_hold_valid", 32'(bus.mem_valid), 32'd1);
         chk("single_hold_addr", bus.mem_addr, 32'h0000_1004);
      end
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      chk("single_done_valid", 32'(bus.mem_valid), 32'd0);
      chk("single_done_empty", 32'(empty), 32'd1);
   endtask

   task automatic test_fill();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         offer(32'h0000_0100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'b1111);
         step();
      end
      chk("fill_st_ready", 32'(bus.st_ready), 32'd0);
      chk("fill_count", 32'(count), 32'd4);
      bus.st_valid = 1'b0;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("fill_b2b_valid", 32'(bus.mem_valid), 32'd1);
         step();
         if (i == 0) begin
            chk("fill_ready_after_retire", 32'(bus.st_ready), 32'd1);
            chk("fill_count_after_retire", 32'(count), 32'd3);
         end
      end
      bus.mem_ready = 1'b0;
      chk("fill_drained_valid", 32'(bus.mem_valid), 32'd0);
      chk("fill_sb_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic test_random();
      int n_acc = 0;
      int cycles = 0;
      while (n_acc < 10 && cycles < 400) begin
         bus.st_valid  = 1'($urandom_range(0, 1));
         bus.mem_ready = 1'($urandom_range(0, 1));
         bus.st_addr   = $urandom;
         bus.st_wdata  = $urandom;
         bus.st_wmask  = 4'($urandom_range(1, 15));
         if (bus.st_valid && bus.st_ready) n_acc++;
         step();
         cycles++;
      end
      chk("rand_accepted", 32'(n_acc), 32'd10);
      bus.st_valid  = 1'b0;
      bus.mem_ready = 1'b1;
      while (sb.size() != 0 && cycles < 400) begin
         step();
         cycles++;
      end
      bus.mem_ready = 1'b0;
      chk("rand_sb_drained", 32'(sb.size()), 32'd0);
      chk("rand_empty", 32'(empty), 32'd1);
   endtask

   task automatic test_hazard();
      bus.mem_ready = 1'b0;
      ld_addr = 32'h0000_0203;
      offer(32'h0000_0200, 32'h0000_0055, 4'b0001);
      step();
      bus.st_valid = 1'b0;
      chk("haz_pending", 32'(ld_hazard), 32'd1);
      ld_addr = 32'h0000_0204;
      #1;
      chk("haz_next_word", 32'(ld_hazard), 32'd0);
      ld_addr = 32'h0000_0203;
      step();
      chk("haz_on_bus", 32'(ld_hazard), 32'd1);
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      chk("haz_retired", 32'(ld_hazard), 32'd0);
   endtask

   task automatic test_zero_mask();
      bus.mem_ready = 1'b1;
      offer(32'h0000_0300, 32'hDEAD_BEEF, 4'b0000);
      chk("zm_st_ready", 32'(bus.st_ready), 32'd1);
      step();
      bus.st_valid = 1'b0;
      chk("zm_count", 32'(count), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("zm_no_write", 32'(bus.mem_valid), 32'd0);
         step();
      end
      bus.mem_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int waits = 0;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         offer(32'h0000_0400 + 32'(4 * i), 32'h5A5A_0000 + 32'(i), 4'b0011);
         step();
      end
      bus.st_valid = 1'b0;
      while (bus.mem_valid !== 1'b1 && waits < 10) begin
         step();
         waits++;
      end
      chk("rm_pre_valid", 32'(bus.mem_valid), 32'd1);
      chk("rm_pre_count", 32'(count), 32'd3);
      resetn = 1'b0;
      #1;
      chk("rm_async_valid", 32'(bus.mem_valid), 32'd0);
      chk("rm_async_count", 32'(count), 32'd0);
      chk("rm_async_empty", 32'(empty), 32'd1);
      step();
      resetn = 1'b1;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rm_no_stale", 32'(bus.mem_valid), 32'd0);
      end
      bus.mem_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_random();
      test_hazard();
      test_zero_mask();
      test_reset_mid();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
